spi_slv: RTL and testbench

//  SPI mode-0 responder, the far end of spi_drv: receives MOSI words and returns MISO words, MSB first.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_slv_if.sv | 31 +++
 rtl/spi_sync.sv | 31 +++
 rtl/spi_slv.sv | 140 ++++++++++++++
 tb/tb_spi_slv.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types, defaults and width helper for the SPI mode-0 responder
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } spi_slv_state_t;

   localparam int SPI_MAXLEN_DFLT = 16;

   // Bit counter width: must hold the value maxlen itself, matching the master's n_clks.
   function automatic int cnt_w(input int maxlen);
      return $clog2(maxlen) + 1;
   endfunction

endpackage

// File: rtl/spi_slv_if.sv
// rtl/spi_slv_if.sv - SPI pins plus local tx/rx client handshake for spi_slv
interface spi_slv_if #(
   parameter int SPI_MAXLEN = spi_pkg::SPI_MAXLEN_DFLT
);
   import spi_pkg::*;

   localparam int CW = cnt_w(SPI_MAXLEN);

   logic                  sclk;
   logic                  ss_n;
   logic                  mosi;
   logic                  miso;
   logic [SPI_MAXLEN-1:0] tx_data;
   logic                  tx_load;
   logic                  busy;
   logic [SPI_MAXLEN-1:0] rx_data;
   logic [CW-1:0]         rx_nbits;
   logic                  rx_overrun;
   logic                  rx_valid;

   modport slave (
      input  sclk, ss_n, mosi, tx_data, tx_load,
      output miso, busy, rx_data, rx_nbits, rx_overrun, rx_valid
   );

   modport master (
      output sclk, ss_n, mosi, tx_data, tx_load,
      input  miso, busy, rx_data, rx_nbits, rx_overrun, rx_valid
   );

endinterface

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - pin synchronizer chain with prev flop for edge detection
module spi_sync #(
   parameter int STAGES  = 2,
   parameter bit RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic areset_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk_i or posedge areset_i) begin
      if (areset_i) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = sync_q[STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slv.sv
// rtl/spi_slv.sv - SPI mode-0 responder, oversampled in the system clock domain
module spi_slv
   import spi_pkg::*;
#(
   parameter int SPI_MAXLEN  = SPI_MAXLEN_DFLT,
   parameter int SYNC_STAGES = 2
) (
   input  logic     clk_i,
   input  logic     areset_i,
   spi_slv_if.slave bus
);

   localparam int CW = cnt_w(SPI_MAXLEN);

   logic sclk_rise, sclk_fall, ss_rise, ss_fall;
   logic mosi_s;
   logic unused_sclk_lvl, unused_ss_lvl, unused_mosi_rise, unused_mosi_fall;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk_i(clk_i), .areset_i(areset_i), .d_i(bus.sclk),
      .level_o(unused_sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   // SS_N resets high so a reset release while deselected never looks like a frame start.
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
      .clk_i(clk_i), .areset_i(areset_i), .d_i(bus.ss_n),
      .level_o(unused_ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk_i(clk_i), .areset_i(areset_i), .d_i(bus.mosi),
      .level_o(mosi_s), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
   );

   spi_slv_state_t        state_q, state_d;
   logic [SPI_MAXLEN-1:0] tx_hold_q, tx_hold_d;
   logic [SPI_MAXLEN-1:0] tx_sr_q, tx_sr_d;
   logic [SPI_MAXLEN-1:0] rx_sr_q, rx_sr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  ovr_q, ovr_d;
   logic                  busy_q, busy_d;
   logic                  miso_q, miso_d;
   logic [SPI_MAXLEN-1:0] rx_data_q, rx_data_d;
   logic [CW-1:0]         rx_nbits_q, rx_nbits_d;
   logic                  rx_ovr_q, rx_ovr_d;
   logic                  rx_valid_q, rx_valid_d;

   always_ff @(posedge clk_i or posedge areset_i) begin
      if (areset_i) begin
         state_q    <= IDLE;
         tx_hold_q  <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         cnt_q      <= '0;
         ovr_q      <= 1'b0;
         busy_q     <= 1'b0;
         miso_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_nbits_q <= '0;
         rx_ovr_q   <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_hold_q  <= tx_hold_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         cnt_q      <= cnt_d;
         ovr_q      <= ovr_d;
         busy_q     <= busy_d;
         miso_q     <= miso_d;
         rx_data_q  <= rx_data_d;
         rx_nbits_q <= rx_nbits_d;
         rx_ovr_q   <= rx_ovr_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      // tx_hold_d doubles as the frame-start word so a same-cycle load goes straight out.
      tx_hold_d  = bus.tx_load ? bus.tx_data : tx_hold_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      cnt_d      = cnt_q;
      ovr_d      = ovr_q;
      busy_d     = busy_q;
      miso_d     = miso_q;
      rx_data_d  = rx_data_q;
      rx_nbits_d = rx_nbits_q;
      rx_ovr_d   = rx_ovr_q;
      rx_valid_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d = ACTIVE;
               tx_sr_d = tx_hold_d;
               miso_d  = tx_hold_d[SPI_MAXLEN-1];
               rx_sr_d = '0;
               cnt_d   = '0;
               ovr_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end
         ACTIVE: begin
            if (ss_rise) begin
               state_d = DONE;
            end else begin
               if (sclk_rise) begin
                  rx_sr_d = {rx_sr_q[SPI_MAXLEN-2:0], mosi_s};
                  if (cnt_q == CW'(SPI_MAXLEN)) ovr_d = 1'b1;
                  else                          cnt_d = cnt_q + CW'(1);
               end
               if (sclk_fall) begin
                  tx_sr_d = {tx_sr_q[SPI_MAXLEN-2:0], 1'b0};
                  miso_d  = tx_sr_d[SPI_MAXLEN-1];
               end
            end
         end
         DONE: begin
            state_d    = IDLE;
            rx_data_d  = rx_sr_q;
            rx_nbits_d = cnt_q;
            rx_ovr_d   = ovr_q;
            rx_valid_d = 1'b1;
            busy_d     = 1'b0;
            miso_d     = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.miso       = miso_q;
   assign bus.busy       = busy_q;
   assign bus.rx_data    = rx_data_q;
   assign bus.rx_nbits   = rx_nbits_q;
   assign bus.rx_overrun = rx_ovr_q;
   assign bus.rx_valid   = rx_valid_q;

endmodule

// File: tb/tb_spi_slv.sv
// tb/tb_spi_slv.sv - directed bench: bit-banged mode-0 master against spi_slv
module tb_spi_slv;

   localparam int HALF = 8;

   logic clk;
   logic areset;
   int   checks = 0;
   int   errors = 0;
   int   pulses = 0;

   spi_slv_if #(.SPI_MAXLEN(16)) bus ();

   spi_slv #(.SPI_MAXLEN(16), .SYNC_STAGES(2)) dut (
      .clk_i   (clk),
      .areset_i(areset),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(negedge clk) if (bus.rx_valid) pulses++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic load_tx(input logic [15:0] v);
      @(negedge clk);
      bus.tx_data = v;
      bus.tx_load = 1'b1;
      @(negedge clk);
      bus.tx_load = 1'b0;
   endtask

   // Leaves SS_N low and SCLK low; the caller decides how the frame ends.
   task automatic spi_frame(input int nbits, input logic [31:0] mosi_w, output logic [31:0] miso_w);
      miso_w = '0;
      @(negedge clk);
      bus.ss_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = nbits - 1; i >= 0; i--) begin
         bus.mosi = mosi_w[i];
         repeat (HALF) @(negedge clk);
         miso_w = {miso_w[30:0], bus.miso};
         bus.sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         bus.sclk = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      bus.mosi = 1'b0;
   endtask

   task automatic end_frame(output int lat);
      lat = 0;
      bus.ss_n = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.rx_valid && lat == 0) lat = k;
      end
   endtask

   initial begin
      logic [31:0] m;
      int          lat;
      int          p0;

      areset      = 1'b1;
      bus.sclk    = 1'b0;
      bus.ss_n    = 1'b1;
      bus.mosi    = 1'b0;
      bus.tx_data = '0;
      bus.tx_load = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_miso",  {31'd0, bus.miso}, 32'd0);
      check_eq("rst_busy",  {31'd0, bus.busy}, 32'd0);
      check_eq("rst_data",  {16'd0, bus.rx_data}, 32'd0);
      check_eq("rst_nbits", {27'd0, bus.rx_nbits}, 32'd0);
      check_eq("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
      areset = 1'b0;
      repeat (5) @(negedge clk);

      // 1: full 16-bit exchange
      load_tx(16'hA55A);
      p0 = pulses;
      spi_frame(16, 32'hD1D1, m);
      check_eq("t1_busy", {31'd0, bus.busy}, 32'd1);
      end_frame(lat);
      check_eq("t1_latency", lat, 4);
      check_eq("t1_pulses", pulses - p0, 1);
      check_eq("t1_data", {16'd0, bus.rx_data}, 32'h0000D1D1);
      check_eq("t1_nbits", {27'd0, bus.rx_nbits}, 32'd16);
      check_eq("t1_ovr", {31'd0, bus.rx_overrun}, 32'd0);
      check_eq("t1_miso", m, 32'h0000A55A);
      check_eq("t1_busy_end", {31'd0, bus.busy}, 32'd0);

      // 2: 8-bit frame
      load_tx(16'h5A00);
      spi_frame(8, 32'hC3, m);
      end_frame(lat);
      check_eq("t2_data", {16'd0, bus.rx_data}, 32'h000000C3);
      check_eq("t2_nbits", {27'd0, bus.rx_nbits}, 32'd8);
      check_eq("t2_miso", m, 32'h0000005A);

      // 3: hold register is not consumed
      p0 = pulses;
      spi_frame(8, 32'hC3, m);
      end_frame(lat);
      check_eq("t3_miso_a", m, 32'h0000005A);
      spi_frame(8, 32'hC3, m);
      end_frame(lat);
      check_eq("t3_miso_b", m, 32'h0000005A);
      check_eq("t3_pulses", pulses - p0, 2);

      // 4: 20 clocks overruns a 16-bit frame; MISO zero past bit 16
      spi_frame(20, 32'h000FFFFF, m);
      end_frame(lat);
      check_eq("t4_nbits", {27'd0, bus.rx_nbits}, 32'd16);
      check_eq("t4_data", {16'd0, bus.rx_data}, 32'h0000FFFF);
      check_eq("t4_ovr", {31'd0, bus.rx_overrun}, 32'd1);
      check_eq("t4_miso", m, 32'h0005A000);

      // 5: reset mid-frame aborts with no rx_valid
      p0 = pulses;
      spi_frame(5, 32'h16, m);
      check_eq("t5_busy_mid", {31'd0, bus.busy}, 32'd1);
      areset = 1'b1;
      @(negedge clk);
      check_eq("t5_rst_busy", {31'd0, bus.busy}, 32'd0);
      check_eq("t5_rst_data", {16'd0, bus.rx_data}, 32'd0);
      check_eq("t5_rst_nbits", {27'd0, bus.rx_nbits}, 32'd0);
      check_eq("t5_rst_ovr", {31'd0, bus.rx_overrun}, 32'd0);
      check_eq("t5_rst_miso", {31'd0, bus.miso}, 32'd0);
      bus.ss_n = 1'b1;
      repeat (5) @(negedge clk);
      areset = 1'b0;
      repeat (30) @(negedge clk);
      check_eq("t5_no_pulse", pulses - p0, 0);
      load_tx(16'h1234);
      spi_frame(16, 32'hBEEF, m);
      end_frame(lat);
      check_eq("t5_data", {16'd0, bus.rx_data}, 32'h0000BEEF);
      check_eq("t5_nbits", {27'd0, bus.rx_nbits}, 32'd16);
      check_eq("t5_miso", m, 32'h00001234);

      // 6: partial frame, then SCLK activity while deselected
      load_tx(16'h5A00);
      spi_frame(3, 32'h5, m);
      end_frame(lat);
      check_eq("t6_nbits", {27'd0, bus.rx_nbits}, 32'd3);
      check_eq("t6_data", {16'd0, bus.rx_data}, 32'h00000005);
      check_eq("t6_miso", m, 32'h00000002);
      p0 = pulses;
      for (int i = 0; i < 6; i++) begin
         bus.mosi = i[0];
         repeat (HALF) @(negedge clk);
         bus.sclk = ~bus.sclk;
      end
      repeat (20) @(negedge clk);
      check_eq("t6_idle_pulses", pulses - p0, 0);
      check_eq("t6_idle_busy", {31'd0, bus.busy}, 32'd0);
      check_eq("t6_idle_data", {16'd0, bus.rx_data}, 32'h00000005);

      // 7: zero-bit frame
      p0 = pulses;
      spi_frame(0, 32'h0, m);
      end_frame(lat);
      check_eq("t7_pulses", pulses - p0, 1);
      check_eq("t7_nbits", {27'd0, bus.rx_nbits}, 32'd0);
      check_eq("t7_data", {16'd0, bus.rx_data}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
